fir_seq: RTL

FIR_SEQ -- requirements
Module: fir_seq

---
 rtl/fir_pkg.sv | 36 +++
 rtl/fir_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fir_pkg.sv
// Shared constants for the FIR command sequencer and anything that talks to it:
// burst length, data width, command opcodes and the sequencer state encoding.
package fir_pkg;

  // Default burst length (beats per WIND/LOAD) and data width.
  localparam int NTAPS = 16;
  localparam int DW    = 16;

  // Command opcodes carried on cmd_op.
  localparam logic [1:0] OP_WIND = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  // Sequencer states as an enum for readable benches and waveforms.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WIND = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  // Same encoding as plain constants, so the state register stays a plain vector.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WIND = 3'd1;
  localparam logic [2:0] ST_LOAD = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  // True for the three states that move data words to the filter.
  function automatic logic is_burst(input logic [2:0] st);
    return (st == ST_WIND) || (st == ST_LOAD) || (st == ST_RUN);
  endfunction

endpackage

// File: rtl/fir_seq.sv
// Command sequencer in front of a FIR filter.
// Accepts one command at a time (WIND / LOAD / RUN), then streams a burst of
// data words onto the filter's wind / load / in_valid strobes with one cycle
// of latency, finishing with a single-cycle done pulse.
//
// Handshakes: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; a data word transfers on a rising edge where
// s_valid and s_ready are both high. Ready never depends on valid, and a
// producer holds its payload stable until the transfer happens.
module fir_seq #(
  parameter int NTAPS = fir_pkg::NTAPS,
  parameter int DW    = fir_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [7:0]    cmd_len,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          fir_wind,
  output logic          fir_load,
  output logic          fir_in_valid,
  output logic [DW-1:0] fir_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    dbg_state
);

  import fir_pkg::*;

  // Burst length as an 8-bit target; bursts never exceed 255 beats.
  localparam logic [7:0] NTAPS_8 = 8'(NTAPS);

  // Sequencer state and beat bookkeeping.
  logic [2:0]    r_state;
  logic [7:0]    r_cnt;
  logic [7:0]    r_target;

  // Registered outputs.
  logic          r_cmd_ready;
  logic          r_fir_wind;
  logic          r_fir_load;
  logic          r_fir_in_valid;
  logic [DW-1:0] r_fir_data;
  logic          r_done;
  logic          r_err;

  // Combinational helpers.
  logic [2:0]    w_state_nxt;
  logic          w_cmd_acc;
  logic          w_cmd_legal;
  logic          w_in_burst;
  logic          w_s_ready;
  logic          w_beat;
  logic [7:0]    w_cnt_nxt;
  logic          w_last;

  // cmd_ready is registered, so it already implies the state is IDLE.
  assign w_cmd_acc   = cmd_valid && r_cmd_ready;
  assign w_cmd_legal = (cmd_op != OP_ILL);

  // Words are taken only in a burst state and only until the target is met.
  assign w_in_burst  = is_burst(r_state);
  assign w_s_ready   = w_in_burst && (r_cnt < r_target);
  assign w_beat      = s_valid && w_s_ready;

  // Count cannot wrap: it only advances while strictly below an 8-bit target.
  assign w_cnt_nxt   = r_cnt + 8'd1;
  assign w_last      = w_beat && (w_cnt_nxt == r_target);

  // Next-state selection for the sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_acc) begin
          case (cmd_op)
            OP_WIND: w_state_nxt = ST_WIND;
            OP_LOAD: w_state_nxt = ST_LOAD;
            OP_RUN:  w_state_nxt = (cmd_len == 8'd0) ? ST_FIN : ST_RUN;
            default: w_state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_WIND, ST_LOAD, ST_RUN: begin
        // Leave on the same edge that registers the final strobe.
        if (w_last) begin
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Beat counter and burst target: cleared and latched when a command is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 8'd0;
      r_target <= 8'd0;
    end else if ((r_state == ST_IDLE) && w_cmd_acc) begin
      r_cnt <= 8'd0;
      case (cmd_op)
        OP_WIND: r_target <= NTAPS_8;
        OP_LOAD: r_target <= NTAPS_8;
        OP_RUN:  r_target <= cmd_len;
        default: r_target <= 8'd0;
      endcase
    end else if (w_beat) begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Command-side ready: raised one cycle after the FSM has settled in IDLE,
  // so it is low during reset, during FIN and during the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_ready <= 1'b0;
    end else begin
      r_cmd_ready <= (r_state == ST_IDLE) && !(w_cmd_acc && w_cmd_legal);
    end
  end

  // Filter strobes: exactly one strobe per beat, chosen by the burst type.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fir_wind     <= 1'b0;
      r_fir_load     <= 1'b0;
      r_fir_in_valid <= 1'b0;
    end else begin
      r_fir_wind     <= w_beat && (r_state == ST_WIND);
      r_fir_load     <= w_beat && (r_state == ST_LOAD);
      r_fir_in_valid <= w_beat && (r_state == ST_RUN);
    end
  end

  // Filter data: captured on a beat, otherwise held so stalls never replay a word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fir_data <= '0;
    end else if (w_beat) begin
      r_fir_data <= s_data;
    end
  end

  // Completion and illegal-opcode pulses, each one cycle wide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= (r_state == ST_FIN);
      r_err  <= (r_state == ST_IDLE) && w_cmd_acc && !w_cmd_legal;
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign s_ready      = w_s_ready;
  assign fir_wind     = r_fir_wind;
  assign fir_load     = r_fir_load;
  assign fir_in_valid = r_fir_in_valid;
  assign fir_data     = r_fir_data;
  assign busy         = (r_state != ST_IDLE);
  assign done         = r_done;
  assign err          = r_err;
  assign dbg_state    = r_state;

endmodule
